// File: rtl/gpio_in_filter_pkg24.sv
// Shared constants for the GPIO input conditioning stage: register map, reset values, defaults.
package gpio_in_filter_pkg24;

  localparam int unsigned NUM_PINS_DEF = 16;
  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned ADDR_W       = 6;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned PRE_W        = 16;

  // Word index of each register (byte offset = index * 4)
  typedef enum logic [3:0] {
    REG_FILT_EN  = 4'h0,
    REG_PRESCALE = 4'h1,
    REG_DEB_CNT  = 4'h2,
    REG_RAW      = 4'h3,
    REG_FILT     = 4'h4
  } reg_idx_e;

  localparam logic [15:0]      FILT_EN_RST  = 16'h0000;
  localparam logic [PRE_W-1:0] PRESCALE_RST = 16'h0000;
  localparam int unsigned      DEB_CNT_RST  = 4;

endpackage

// File: rtl/gpio_filt_chan24.sv
// One pad channel: 2-flop synchroniser followed by a tick-timed debounce filter.
module gpio_filt_chan24 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pad,
  input  logic             tick,
  input  logic             en,
  input  logic [CNT_W-1:0] deb_cnt,
  input  logic             clr,
  output logic             sync,
  output logic             filt
);

  localparam int unsigned CW1 = CNT_W + 1;

  logic             meta;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             filt_nxt;
  logic [CW1-1:0]   cnt_inc;
  logic [CW1-1:0]   deb_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= pad;
      sync <= meta;
      filt <= filt_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // A threshold of zero behaves as one; compare one bit wider so cnt+1 cannot wrap
  always_comb begin
    filt_nxt = filt;
    cnt_nxt  = cnt;
    deb_eff  = (deb_cnt == '0) ? CW1'(1) : {1'b0, deb_cnt};
    cnt_inc  = {1'b0, cnt} + CW1'(1);
    if (!en) begin
      filt_nxt = sync;
      cnt_nxt  = '0;
    end else if (clr) begin
      cnt_nxt = '0;
    end else if (tick) begin
      if (sync == filt) begin
        cnt_nxt = '0;
      end else if (cnt_inc >= deb_eff) begin
        filt_nxt = sync;
        cnt_nxt  = '0;
      end else if (cnt != '1) begin
        cnt_nxt = cnt_inc[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/gpio_in_filter24.sv
// Pad input conditioning for the GPIO block: APB config registers, shared prescaler, per-pin channels.
module gpio_in_filter24
  import gpio_in_filter_pkg24::*;
#(
  parameter int unsigned NUM_PINS = NUM_PINS_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                pclk24,
  input  logic                n_p_reset24,
  input  logic                psel24,
  input  logic                penable24,
  input  logic                pwrite24,
  input  logic [ADDR_W-1:0]   paddr24,
  input  logic [DATA_W-1:0]   pwdata24,
  output logic [DATA_W-1:0]   prdata24,
  input  logic [NUM_PINS-1:0] pad_in24,
  output logic [NUM_PINS-1:0] gpio_pin_in24
);

  logic [NUM_PINS-1:0] filt_en;
  logic [PRE_W-1:0]    prescale;
  logic [PRE_W-1:0]    pre_cnt;
  logic [CNT_W-1:0]    deb_cnt;
  logic [NUM_PINS-1:0] sync_v;
  logic [NUM_PINS-1:0] filt_v;

  logic [3:0] word_c;
  logic       wr_c;
  logic       wr_filt_en_c;
  logic       wr_pre_c;
  logic       wr_deb_c;
  logic       tick_c;
  logic       unused_bits;

  assign word_c       = paddr24[5:2];
  assign wr_c         = psel24 & penable24 & pwrite24;
  assign wr_filt_en_c = wr_c && (word_c == REG_FILT_EN);
  assign wr_pre_c     = wr_c && (word_c == REG_PRESCALE);
  assign wr_deb_c     = wr_c && (word_c == REG_DEB_CNT);
  assign unused_bits  = ^{paddr24[1:0], pwdata24[31:16]};

  // Configuration registers
  always_ff @(posedge pclk24 or negedge n_p_reset24) begin
    if (!n_p_reset24) begin
      filt_en  <= NUM_PINS'(FILT_EN_RST);
      prescale <= PRESCALE_RST;
      deb_cnt  <= CNT_W'(DEB_CNT_RST);
    end else begin
      if (wr_filt_en_c) filt_en  <= pwdata24[NUM_PINS-1:0];
      if (wr_pre_c)     prescale <= pwdata24[PRE_W-1:0];
      if (wr_deb_c)     deb_cnt  <= pwdata24[CNT_W-1:0];
    end
  end

  // A PRESCALE write restarts the period and swallows the tick on that edge
  assign tick_c = (pre_cnt == prescale) && !wr_pre_c;

  always_ff @(posedge pclk24 or negedge n_p_reset24) begin
    if (!n_p_reset24) begin
      pre_cnt <= '0;
    end else if (wr_pre_c || (pre_cnt == prescale)) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_chan
    gpio_filt_chan24 #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk     (pclk24),
      .rst_n   (n_p_reset24),
      .pad     (pad_in24[i]),
      .tick    (tick_c),
      .en      (filt_en[i]),
      .deb_cnt (deb_cnt),
      .clr     (wr_deb_c),
      .sync    (sync_v[i]),
      .filt    (filt_v[i])
    );
  end

  // Zero-wait read path
  always_comb begin
    prdata24 = '0;
    if (psel24 && !pwrite24) begin
      case (word_c)
        REG_FILT_EN:  prdata24 = DATA_W'(filt_en);
        REG_PRESCALE: prdata24 = DATA_W'(prescale);
        REG_DEB_CNT:  prdata24 = DATA_W'(deb_cnt);
        REG_RAW:      prdata24 = DATA_W'(sync_v);
        REG_FILT:     prdata24 = DATA_W'(filt_v);
        default:      prdata24 = '0;
      endcase
    end
  end

  assign gpio_pin_in24 = filt_v;

endmodule
